// File: rtl/bram_tx_packet_reader_if.sv
// Bundle of the command, BRAM read port and AXI4-Stream master signals
// of the TX BRAM packet reader. The master modport is the reader side,
// the slave modport is the environment (BRAM, serializer, control).
interface bram_tx_packet_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 11
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic              err_len;

    modport master (
        input  start, base_addr, len, bram_dout, m_axis_tready,
        output bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               busy, done, err_len
    );

    modport slave (
        output start, base_addr, len, bram_dout, m_axis_tready,
        input  bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               busy, done, err_len
    );
endinterface

// File: rtl/bram_tx_packet_reader.sv
// TX BRAM packet reader: on an accepted start it reads len words from the
// TX BRAM (1-cycle read latency) starting at base_addr and streams them on
// an AXI4-Stream master through a 2-entry output FIFO with full backpressure.
module bram_tx_packet_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 13,
    parameter int LEN_W     = 11,
    parameter int LIMIT_LEN = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    bram_tx_packet_reader_if.master bus
);

    localparam logic [LEN_W-1:0] LIMIT_LEN_L = LEN_W'(LIMIT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [ADDR_W-1:0] rd_addr_r;
    logic [LEN_W-1:0]  rd_left_r;
    logic [LEN_W-1:0]  tx_left_r;
    logic              inflight_r;
    logic [DATA_W-1:0] fifo0_r;
    logic [DATA_W-1:0] fifo1_r;
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        buf_cnt_r;
    logic              err_len_r;

    logic              len_ok_s;
    logic              start_ok_s;
    logic              tvalid_s;
    logic              pop_s;
    logic [2:0]        occ_s;
    logic              bram_en_s;
    logic [ADDR_W-1:0] bram_addr_s;
    logic [DATA_W-1:0] head_s;
    logic [DATA_W-1:0] tdata_s;
    logic              tlast_s;
    logic              busy_s;
    logic              done_s;

    assign len_ok_s   = (bus.len != {LEN_W{1'b0}}) && (bus.len <= LIMIT_LEN_L);
    assign start_ok_s = (state_r == ST_IDLE) && bus.start && len_ok_s;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave READ on the handshake of the final word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = start_ok_s ? ST_READ : ST_IDLE;
            ST_READ: state_nxt_s = (pop_s && tlast_s) ? ST_DONE : ST_READ;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/issue logic. A word leaving the FIFO this cycle frees its slot
    // for a read issued in the same cycle; without that credit a 2-entry FIFO
    // behind a 1-cycle BRAM could not sustain one word per cycle.
    always_comb begin
        tvalid_s    = (buf_cnt_r != 2'd0);
        pop_s       = tvalid_s && bus.m_axis_tready;
        occ_s       = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        bram_en_s   = (state_r == ST_READ) && (rd_left_r != {LEN_W{1'b0}}) && (occ_s < 3'd2);
        bram_addr_s = bram_en_s ? rd_addr_r : {ADDR_W{1'b0}};
        head_s      = rd_ptr_r ? fifo1_r : fifo0_r;
        tdata_s     = tvalid_s ? head_s : {DATA_W{1'b0}};
        tlast_s     = tvalid_s && (tx_left_r == LEN_W'(1));
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_READ: busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Read address/count: load on accepted start, advance per issued read
    // (address wraps naturally at 2**ADDR_W).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr_r <= {ADDR_W{1'b0}};
            rd_left_r <= {LEN_W{1'b0}};
        end else if (start_ok_s) begin
            rd_addr_r <= bus.base_addr;
            rd_left_r <= bus.len;
        end else if (bram_en_s) begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
            rd_left_r <= rd_left_r - LEN_W'(1);
        end else begin
            rd_addr_r <= rd_addr_r;
            rd_left_r <= rd_left_r;
        end
    end

    // Words still to be handed to the stream; drives tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_left_r <= {LEN_W{1'b0}};
        end else if (start_ok_s) begin
            tx_left_r <= bus.len;
        end else if (pop_s) begin
            tx_left_r <= tx_left_r - LEN_W'(1);
        end else begin
            tx_left_r <= tx_left_r;
        end
    end

    // Read-in-flight flag and rejected-start pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inflight_r <= 1'b0;
            err_len_r  <= 1'b0;
        end else begin
            inflight_r <= bram_en_s;
            err_len_r  <= (state_r == ST_IDLE) && bus.start && !len_ok_s;
        end
    end

    // Two-entry output FIFO: BRAM data is written the cycle after its read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fifo0_r   <= {DATA_W{1'b0}};
            fifo1_r   <= {DATA_W{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            buf_cnt_r <= 2'd0;
        end else begin
            if (inflight_r) begin
                if (wr_ptr_r) begin
                    fifo1_r <= bus.bram_dout;
                end else begin
                    fifo0_r <= bus.bram_dout;
                end
                wr_ptr_r <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r <= pop_s ? ~rd_ptr_r : rd_ptr_r;
            case ({inflight_r, pop_s})
                2'b10:   buf_cnt_r <= buf_cnt_r + 2'd1;
                2'b01:   buf_cnt_r <= buf_cnt_r - 2'd1;
                default: buf_cnt_r <= buf_cnt_r;
            endcase
        end
    end

    assign bus.bram_en       = bram_en_s;
    assign bus.bram_addr     = bram_addr_s;
    assign bus.m_axis_tvalid = tvalid_s;
    assign bus.m_axis_tdata  = tdata_s;
    assign bus.m_axis_tlast  = tlast_s;
    assign bus.busy          = busy_s;
    assign bus.done          = done_s;
    assign bus.err_len       = err_len_r;

endmodule

// File: tb/tb_bram_tx_packet_reader.sv
// Scoreboard bench for bram_tx_packet_reader: each start pushes the expected
// words into a queue; a monitor pops and compares on every stream handshake.
module tb_bram_tx_packet_reader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int LEN_W  = 11;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    bram_tx_packet_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    bram_tx_packet_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LIMIT_LEN(1024)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    logic [31:0] bram_mem [0:8191];
    always @(posedge aclk) begin
        if (bus.bram_en) bus.bram_dout <= bram_mem[bus.bram_addr];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    int          hs_cnt = 0;
    int          bram_en_cnt = 0;
    bit          tog_mode = 1'b0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = 32'd0;
    logic        pl = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // tready driver: constant 1 or toggling each cycle
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (tog_mode) bus.m_axis_tready = ~bus.m_axis_tready;
            else          bus.m_axis_tready = 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                pv = 1'b0;
            end else begin
                if (bus.bram_en) bram_en_cnt++;
                if (pv && !pr) begin
                    chk("tvalid_held", bus.m_axis_tvalid, 1);
                    chk("tdata_held", bus.m_axis_tdata, pd);
                    chk("tlast_held", bus.m_axis_tlast, pl);
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    hs_cnt++;
                    chk("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tdata", bus.m_axis_tdata, e[31:0]);
                        chk("tlast", bus.m_axis_tlast, e[32]);
                    end
                end
                pv = bus.m_axis_tvalid;
                pr = bus.m_axis_tready;
                pd = bus.m_axis_tdata;
                pl = bus.m_axis_tlast;
            end
        end
    end

    task automatic push_exp(input logic [12:0] base, input logic [10:0] len);
        logic [12:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 13'(i);
            exp_q.push_back({(i == int'(len) - 1), bram_mem[a]});
        end
    endtask

    task automatic run_packet(input logic [12:0] base, input logic [10:0] len,
                              input bit timing, input bit inject, input string tag);
        int cyc;
        int done_cyc;
        int fv_cyc;
        done_cyc = -1;
        fv_cyc   = -1;
        push_exp(base, len);
        bus.start = 1'b1; bus.base_addr = base; bus.len = len;
        @(posedge aclk); #1;
        bus.start = 1'b0; bus.base_addr = ~base; bus.len = 11'd3;
        cyc = 1;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge aclk);
            if (cyc == 1) begin
                chk({tag, "_busy_on"}, bus.busy, 1);
                if (timing) begin
                    chk({tag, "_bram_en_first"}, bus.bram_en, 1);
                    chk({tag, "_bram_addr_first"}, bus.bram_addr, base);
                end
            end
            if (inject && cyc == 2) begin
                bus.start = 1'b1; bus.base_addr = 13'h100; bus.len = 11'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.m_axis_tvalid && fv_cyc < 0) fv_cyc = cyc;
            if (bus.done) begin
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, bus.busy, 0);
            end
            @(posedge aclk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
        if (timing) begin
            chk({tag, "_first_valid_cycle"}, fv_cyc, 3);
            chk({tag, "_done_cycle"}, done_cyc, int'(len) + 3);
        end
        chk({tag, "_all_words_out"}, exp_q.size(), 0);
        @(negedge aclk);
        chk({tag, "_done_one_cycle"}, bus.done, 0);
    endtask

    task automatic run_err(input logic [10:0] len, input string tag);
        int en0;
        en0 = bram_en_cnt;
        bus.start = 1'b1; bus.base_addr = 13'h020; bus.len = len;
        @(posedge aclk); #1;
        bus.start = 1'b0;
        @(negedge aclk);
        chk({tag, "_err_len"}, bus.err_len, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk({tag, "_err_len_pulse"}, bus.err_len, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
        chk({tag, "_no_bram_en"}, bram_en_cnt, en0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bram_en"}, bus.bram_en, 0);
        chk({tag, "_bram_addr"}, bus.bram_addr, 0);
        chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        chk({tag, "_tdata"}, bus.m_axis_tdata, 0);
        chk({tag, "_tlast"}, bus.m_axis_tlast, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err_len"}, bus.err_len, 0);
    endtask

    initial begin
        int hs0;
        aresetn = 1'b0;
        bus.start = 1'b0; bus.base_addr = 13'h0; bus.len = 11'h0;
        for (int i = 0; i < 8192; i++) bram_mem[i] = 32'(i);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check_all_zero("reset");

        // T1 + T5 part: start during busy ignored
        run_packet(13'h010, 11'd4, 1'b1, 1'b1, "t1");
        // T2: toggling tready
        tog_mode = 1'b1;
        run_packet(13'h200, 11'd8, 1'b0, 1'b0, "t2");
        tog_mode = 1'b0;
        @(posedge aclk); #1;
        // T3: address wrap
        run_packet(13'h1FFE, 11'd4, 1'b1, 1'b0, "t3");
        // T4: illegal lengths, plus the largest legal length
        run_err(11'd0, "t4_len0");
        run_err(11'd1025, "t4_len1025");
        run_packet(13'h1000, 11'd1024, 1'b1, 1'b0, "t4_len1024");
        // T5: single word
        run_packet(13'h555, 11'd1, 1'b1, 1'b0, "t5");

        // T6: reset after 3 of 10 words
        push_exp(13'h040, 11'd10);
        hs0 = hs_cnt;
        bus.start = 1'b1; bus.base_addr = 13'h040; bus.len = 11'd10;
        @(posedge aclk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (hs_cnt - hs0 >= 3) break;
            @(posedge aclk); #1;
        end
        chk("t6_three_words", hs_cnt - hs0, 3);
        aresetn = 1'b0;
        #1;
        check_all_zero("t6_async");
        exp_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check_all_zero("t6_after");
        run_packet(13'h300, 11'd2, 1'b1, 1'b0, "t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
